// File: rtl/cache_ctrl_pkg.sv
// Shared types for the single-set cache controller: way storage entry and
// the victim/fill sequencing state encoding.
package cache_ctrl_pkg;

  localparam int WAYS      = 8;
  localparam int WAY_W     = 3;
  // Tag storage is sized for the widest supported TAG_W (<= 32); narrower
  // tags are zero-extended on install and compared at full width.
  localparam int TAG_MAX_W = 32;

  typedef logic [TAG_MAX_W-1:0] tag_store_t;

  typedef struct packed {
    logic       valid;
    logic       dirty;
    tag_store_t tag;
  } way_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_REQ,
    ST_WB_WAIT,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_RESP
  } victim_state_t;

endpackage

// File: rtl/victim_select.sv
// Victim choice for a miss: lowest-index invalid way, else the LRU candidate.
// Also flags whether the chosen way holds dirty data needing a writeback.
module victim_select
  import cache_ctrl_pkg::*;
(
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  dirty,
  input  logic [WAY_W-1:0] lru_evict_way,
  output logic [WAY_W-1:0] victim_way,
  output logic             victim_needs_wb
);

  always_comb begin
    victim_way = lru_evict_way;
    // Descending scan so the lowest invalid index wins.
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!valid[i]) victim_way = WAY_W'(i);
    end
    victim_needs_wb = valid[victim_way] & dirty[victim_way];
  end

endmodule

// File: rtl/set_victim_ctrl.sv
// Single-set 8-way tag/state controller: lookup, victim writeback, fill,
// install, and LRU touch reporting.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | ready for a request
// LOOKUP    | tag compare; on miss choose and register victim
// WB_REQ    | present writeback of dirty victim to memory
// WB_WAIT   | wait for writeback completion
// FILL_REQ  | present fill of request tag to memory
// FILL_WAIT | wait for fill completion, then install
// RESP      | completion pulse and LRU update
module set_victim_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TAG_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_write,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             lru_access_valid,
  output logic [WAY_W-1:0] lru_access_way,
  input  logic [WAY_W-1:0] lru_evict_way,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_wb,
  output logic [TAG_W-1:0] mem_req_tag,
  input  logic             mem_done
);

  victim_state_t    state, state_nxt;
  way_entry_t       ways [WAYS];
  logic [TAG_W-1:0] req_tag_q;
  logic             req_write_q;
  logic             hit_q;
  logic [WAY_W-1:0] sel_way_q;

  logic [WAYS-1:0]  valid_vec, dirty_vec, match_vec;
  logic             lookup_hit;
  logic [WAY_W-1:0] lookup_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_needs_wb;

  always_comb begin
    valid_vec  = '0;
    dirty_vec  = '0;
    match_vec  = '0;
    lookup_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      valid_vec[i] = ways[i].valid;
      dirty_vec[i] = ways[i].dirty;
      match_vec[i] = ways[i].valid && (ways[i].tag == tag_store_t'(req_tag_q));
      if (match_vec[i]) lookup_way = WAY_W'(i);
    end
    lookup_hit = |match_vec;
  end

  victim_select u_victim_select (
    .valid           (valid_vec),
    .dirty           (dirty_vec),
    .lru_evict_way   (lru_evict_way),
    .victim_way      (victim_way),
    .victim_needs_wb (victim_needs_wb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (req_valid) state_nxt = ST_LOOKUP;
      ST_LOOKUP: begin
        if (lookup_hit)           state_nxt = ST_RESP;
        else if (victim_needs_wb) state_nxt = ST_WB_REQ;
        else                      state_nxt = ST_FILL_REQ;
      end
      ST_WB_REQ:    if (mem_req_ready) state_nxt = ST_WB_WAIT;
      ST_WB_WAIT:   if (mem_done)      state_nxt = ST_FILL_REQ;
      ST_FILL_REQ:  if (mem_req_ready) state_nxt = ST_FILL_WAIT;
      ST_FILL_WAIT: if (mem_done)      state_nxt = ST_RESP;
      ST_RESP:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode only from state and registered data, so a reset
  // drops mem_req_valid and the response strobes asynchronously.
  always_comb begin
    req_ready        = (state == ST_IDLE);
    mem_req_valid    = (state == ST_WB_REQ) || (state == ST_FILL_REQ);
    mem_req_wb       = (state == ST_WB_REQ);
    mem_req_tag      = '0;
    if (state == ST_WB_REQ)   mem_req_tag = ways[sel_way_q].tag[TAG_W-1:0];
    if (state == ST_FILL_REQ) mem_req_tag = req_tag_q;
    rsp_valid        = (state == ST_RESP);
    rsp_hit          = (state == ST_RESP) && hit_q;
    rsp_way          = (state == ST_RESP) ? sel_way_q : '0;
    lru_access_valid = (state == ST_RESP);
    lru_access_way   = (state == ST_RESP) ? sel_way_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_tag_q   <= '0;
      req_write_q <= 1'b0;
      hit_q       <= 1'b0;
      sel_way_q   <= '0;
      for (int i = 0; i < WAYS; i++) ways[i] <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        req_tag_q   <= req_tag;
        req_write_q <= req_write;
      end
      if (state == ST_LOOKUP) begin
        hit_q     <= lookup_hit;
        sel_way_q <= lookup_hit ? lookup_way : victim_way;
      end
      if (state == ST_FILL_WAIT && mem_done) begin
        ways[sel_way_q].valid <= 1'b1;
        ways[sel_way_q].dirty <= req_write_q;
        ways[sel_way_q].tag   <= tag_store_t'(req_tag_q);
      end
      if (state == ST_RESP && hit_q && req_write_q)
        ways[sel_way_q].dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_set_victim_ctrl.sv
// Directed bench for set_victim_ctrl: hits, fills, dirty writeback,
// memory handshake hold, and reset in the middle of a miss.
module tb_set_victim_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_tag = '0;
  logic        req_write = 1'b0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [2:0]  rsp_way;
  logic        lru_access_valid;
  logic [2:0]  lru_access_way;
  logic [2:0]  lru_evict_way = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_wb;
  logic [11:0] mem_req_tag;
  logic        mem_done = 1'b0;

  int checks = 0;
  int errors = 0;

  set_victim_ctrl #(.TAG_W(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_tag          (req_tag),
    .req_write        (req_write),
    .rsp_valid        (rsp_valid),
    .rsp_hit          (rsp_hit),
    .rsp_way          (rsp_way),
    .lru_access_valid (lru_access_valid),
    .lru_access_way   (lru_access_way),
    .lru_evict_way    (lru_evict_way),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_wb       (mem_req_wb),
    .mem_req_tag      (mem_req_tag),
    .mem_done         (mem_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request while IDLE; returns one step after the accept edge.
  task automatic accept(input logic [11:0] tag, input logic wr);
    req_tag   = tag;
    req_write = wr;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for a memory request, check it, then complete it.
  task automatic mem_op(input string name, input logic exp_wb, input logic [11:0] exp_tag);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_mreq_valid"}, mem_req_valid, 1);
    chk({name, "_mreq_wb"}, mem_req_wb, exp_wb);
    chk({name, "_mreq_tag"}, mem_req_tag, exp_tag);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({name, "_mreq_drop"}, mem_req_valid, 0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic exp_hit, input logic [2:0] exp_way);
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_rsp_valid"}, rsp_valid, 1);
    chk({name, "_rsp_hit"}, rsp_hit, exp_hit);
    chk({name, "_rsp_way"}, rsp_way, exp_way);
    chk({name, "_lru_valid"}, lru_access_valid, 1);
    chk({name, "_lru_way"}, lru_access_way, exp_way);
    tick();
    chk({name, "_rsp_pulse"}, rsp_valid, 0);
    chk({name, "_ready_back"}, req_ready, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // reset values
    tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_mreq_valid", mem_req_valid, 0);
    chk("rst_mreq_wb", mem_req_wb, 0);
    chk("rst_mreq_tag", mem_req_tag, 0);
    chk("rst_lru_valid", lru_access_valid, 0);
    chk("rst_lru_way", lru_access_way, 0);
    rst = 1'b0;
    tick();

    // cold read miss fills way 0
    accept(12'h0A5, 1'b0);
    chk("cold_ready_low", req_ready, 0);
    mem_op("cold_fill", 1'b0, 12'h0A5);
    wait_rsp("cold", 1'b0, 3'd0);

    // re-read hits: response exactly two cycles after accept, no memory traffic
    accept(12'h0A5, 1'b0);
    chk("hit_lookup_rsp", rsp_valid, 0);
    chk("hit_lookup_mreq", mem_req_valid, 0);
    tick();
    chk("hit_rsp_mreq", mem_req_valid, 0);
    wait_rsp("hit", 1'b1, 3'd0);

    // write-miss ways 0..7 with tags 0x100..0x107 (all dirty)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      accept(12'h100 + 12'(i), 1'b1);
      mem_op("wfill", 1'b0, 12'h100 + 12'(i));
      wait_rsp("wfill", 1'b0, 3'(i));
    end

    // full set, LRU picks dirty way 3: writeback 0x103 then fill 0x200
    lru_evict_way = 3'd3;
    accept(12'h200, 1'b0);
    mem_op("evict_wb", 1'b1, 12'h103);
    mem_op("evict_fill", 1'b0, 12'h200);
    wait_rsp("evict", 1'b0, 3'd3);

    // way 3 now clean: evicting it again needs no writeback
    accept(12'h300, 1'b0);
    mem_op("clean_fill", 1'b0, 12'h300);
    wait_rsp("clean", 1'b0, 3'd3);

    // writeback of way 4 held off by memory; stray done and requests ignored
    lru_evict_way = 3'd4;
    accept(12'h400, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1;
      req_tag   = 12'h7FF;
      mem_done  = (k == 2);
      chk("hold_mreq_valid", mem_req_valid, 1);
      chk("hold_mreq_wb", mem_req_wb, 1);
      chk("hold_mreq_tag", mem_req_tag, 12'h104);
      chk("hold_req_ready", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    mem_done  = 1'b0;
    mem_op("hold_wb", 1'b1, 12'h104);
    mem_op("hold_fill", 1'b0, 12'h400);
    wait_rsp("hold", 1'b0, 3'd4);

    // clean fills of all 8 ways, then LRU victim 5 needs no writeback
    do_reset();
    lru_evict_way = 3'd0;
    for (int i = 0; i < 8; i++) begin
      accept(12'h010 + 12'(i), 1'b0);
      mem_op("rfill", 1'b0, 12'h010 + 12'(i));
      wait_rsp("rfill", 1'b0, 3'(i));
    end
    lru_evict_way = 3'd5;
    accept(12'h050, 1'b0);
    mem_op("lru5_fill", 1'b0, 12'h050);
    wait_rsp("lru5", 1'b0, 3'd5);

    // reset while a fill request is presented drops mem_req_valid at once
    accept(12'h060, 1'b0);
    tick();
    chk("rreq_mreq_pre", mem_req_valid, 1);
    rst = 1'b1;
    #1;
    chk("rreq_mreq_async", mem_req_valid, 0);
    tick();
    rst = 1'b0;
    tick();

    // reset in FILL_WAIT abandons the op, no response, ways invalidated
    accept(12'h0A5, 1'b0);
    mem_op("pre_fill", 1'b0, 12'h0A5);
    wait_rsp("pre", 1'b0, 3'd0);
    accept(12'h0B6, 1'b0);
    tick();
    chk("rfw_fill_req", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rfw_mreq", mem_req_valid, 0);
    chk("rfw_rsp", rsp_valid, 0);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("rfw_lru_in_rst", lru_access_valid, 0);
    rst = 1'b0;
    tick();
    chk("rfw_ready", req_ready, 1);
    chk("rfw_rsp_after", rsp_valid, 0);
    accept(12'h0A5, 1'b0);
    mem_op("rfw_refill", 1'b0, 12'h0A5);
    wait_rsp("rfw", 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
